// File: rtl/if_stage_mo.sv
// Multi-outstanding instruction fetch stage: pipelined inst_sram requests, in-order IBUF towards ID,
// full-flush and delay-slot-preserving branch redirects with stale-response discard.
module if_stage_mo #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'hbfc00000
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ds_allowin,
  output logic         fs_to_ds_valid,
  output logic [101:0] fs_to_ds_bus,
  input  logic         flush_valid,
  input  logic [31:0]  flush_pc,
  input  logic         br_valid,
  input  logic [31:0]  br_target,
  output logic         inst_sram_req,
  output logic         inst_sram_wr,
  output logic [1:0]   inst_sram_size,
  output logic [3:0]   inst_sram_wstrb,
  output logic [31:0]  inst_sram_addr,
  output logic [31:0]  inst_sram_wdata,
  input  logic         inst_sram_addr_ok,
  input  logic         inst_sram_data_ok,
  input  logic [31:0]  inst_sram_rdata
);

  localparam int unsigned IbAw = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int unsigned IbCw = $clog2(IBUF_DEPTH + 1);
  localparam int unsigned OsAw = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OsCw = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [4:0]  ExAdel = 5'h04;

  typedef logic [101:0] entry_t;

  function automatic logic [IbAw-1:0] ib_wrap(input logic [IbAw-1:0] p, input int unsigned n);
    int unsigned t;
    t = 32'(p) + n;
    if (t >= IBUF_DEPTH) t -= IBUF_DEPTH;
    return IbAw'(t);
  endfunction

  function automatic logic [OsAw-1:0] os_wrap(input logic [OsAw-1:0] p, input int unsigned n);
    int unsigned t;
    t = 32'(p) + n;
    if (t >= MAX_OUTSTANDING) t -= MAX_OUTSTANDING;
    return OsAw'(t);
  endfunction

  entry_t                     ibuf_q [IBUF_DEPTH];
  logic [IbAw-1:0]            ib_head_q, ib_head_d, ib_wr_idx;
  logic [IbCw-1:0]            ib_cnt_q, ib_cnt_d;
  logic [31:0]                os_pc_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] os_live_q, os_live_d, keep_mask;
  logic [OsAw-1:0]            os_rd_q, os_rd_d, os_wr_idx;
  logic [OsCw-1:0]            os_cnt_q, os_cnt_d;
  logic [31:0]                fetch_pc_q, fetch_pc_d, br_tgt_q, br_tgt_d;
  logic                       slot_pend_q, slot_pend_d, adel_done_q, adel_done_d;
  logic                       aligned, has_space, fire, ret, ret_live, ib_pop, adel_push;
  logic                       live_found, ib_push, ib_trunc;
  entry_t                     ib_wdata;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'd0;

  // IBUF space is reserved at issue so a returning response always has a slot.
  assign aligned   = fetch_pc_q[1:0] == 2'b00;
  assign has_space = (32'(os_cnt_q) < MAX_OUTSTANDING) &&
                     (32'(os_cnt_q) + 32'(ib_cnt_q) < IBUF_DEPTH);
  assign inst_sram_req  = resetn && !flush_valid && !br_valid && has_space && aligned;
  assign inst_sram_addr = fetch_pc_q;
  assign fire           = inst_sram_req && inst_sram_addr_ok;
  assign ret            = inst_sram_data_ok && (os_cnt_q != '0);
  assign ret_live       = ret && os_live_q[os_rd_q];
  assign fs_to_ds_valid = (ib_cnt_q != '0) && !flush_valid;
  assign fs_to_ds_bus   = ibuf_q[ib_head_q];
  assign ib_pop         = fs_to_ds_valid && ds_allowin;
  assign adel_push      = !flush_valid && !br_valid && !aligned && !adel_done_q &&
                          (os_cnt_q == '0) && (32'(ib_cnt_q) < IBUF_DEPTH);
  assign os_wr_idx      = os_wrap(os_rd_q, 32'(os_cnt_q));

  // Oldest in-flight request whose response is still wanted.
  always_comb begin
    keep_mask  = '0;
    live_found = 1'b0;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (i < 32'(os_cnt_q) && !live_found && os_live_q[os_wrap(os_rd_q, i)]) begin
        live_found                     = 1'b1;
        keep_mask[os_wrap(os_rd_q, i)] = 1'b1;
      end
    end
  end

  always_comb begin
    ib_head_d   = ib_head_q;
    ib_cnt_d    = ib_cnt_q;
    os_rd_d     = os_rd_q;
    os_cnt_d    = os_cnt_q;
    os_live_d   = os_live_q;
    fetch_pc_d  = fetch_pc_q;
    br_tgt_d    = br_tgt_q;
    slot_pend_d = slot_pend_q;
    adel_done_d = adel_done_q;
    ib_push     = 1'b0;
    ib_trunc    = 1'b0;
    ib_wdata    = {1'b0, 5'd0, 32'd0, inst_sram_rdata, os_pc_q[os_rd_q]};
    ib_wr_idx   = ib_wrap(ib_head_q, 32'(ib_cnt_q));

    if (flush_valid) begin
      ib_cnt_d    = '0;
      os_live_d   = '0;
      fetch_pc_d  = flush_pc;
      slot_pend_d = 1'b0;
      adel_done_d = 1'b0;
    end else if (br_valid) begin
      adel_done_d = 1'b0;
      if (ib_cnt_q != '0) begin
        // Head is the delay slot: keep it (or let ID take it now), drop everything younger.
        os_live_d   = '0;
        ib_trunc    = 1'b1;
        ib_cnt_d    = ib_pop ? '0 : IbCw'(1);
        ib_head_d   = ib_pop ? ib_wrap(ib_head_q, 1) : ib_head_q;
        fetch_pc_d  = br_target;
        slot_pend_d = 1'b0;
      end else if (live_found) begin
        os_live_d   = keep_mask;
        ib_push     = ret_live;
        fetch_pc_d  = br_target;
        slot_pend_d = 1'b0;
      end else begin
        slot_pend_d = 1'b1;
        br_tgt_d    = br_target;
      end
    end else begin
      ib_push = ret_live || adel_push;
      if (adel_push) begin
        ib_wdata    = {1'b1, ExAdel, fetch_pc_q, 32'd0, fetch_pc_q};
        adel_done_d = 1'b1;
      end
      if (fire) begin
        fetch_pc_d  = slot_pend_q ? br_tgt_q : fetch_pc_q + 32'd4;
        slot_pend_d = 1'b0;
      end
    end

    if (!flush_valid && !ib_trunc) begin
      ib_cnt_d = ib_cnt_q + IbCw'(ib_push) - IbCw'(ib_pop);
      if (ib_pop) ib_head_d = ib_wrap(ib_head_q, 1);
    end

    if (ret) begin
      os_live_d[os_rd_q] = 1'b0;
      os_rd_d            = os_wrap(os_rd_q, 1);
    end
    os_cnt_d = os_cnt_q + OsCw'(fire) - OsCw'(ret);
    if (fire) os_live_d[os_wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ib_head_q   <= '0;
      ib_cnt_q    <= '0;
      os_rd_q     <= '0;
      os_cnt_q    <= '0;
      os_live_q   <= '0;
      fetch_pc_q  <= RESET_PC;
      br_tgt_q    <= '0;
      slot_pend_q <= 1'b0;
      adel_done_q <= 1'b0;
    end else begin
      ib_head_q   <= ib_head_d;
      ib_cnt_q    <= ib_cnt_d;
      os_rd_q     <= os_rd_d;
      os_cnt_q    <= os_cnt_d;
      os_live_q   <= os_live_d;
      fetch_pc_q  <= fetch_pc_d;
      br_tgt_q    <= br_tgt_d;
      slot_pend_q <= slot_pend_d;
      adel_done_q <= adel_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ib_push) ibuf_q[ib_wr_idx] <= ib_wdata;
    if (fire) os_pc_q[os_wr_idx] <= fetch_pc_q;
  end

endmodule

// File: tb/tb_if_stage_mo.sv
// Bench for if_stage_mo: directed steps, SRAM responder model, scoreboard of delivered IBUF entries.
module tb_if_stage_mo;
  localparam logic [31:0] ResetPc = 32'hbfc00000;

  logic         clk = 1'b0;
  logic         resetn, ds_allowin, flush_valid, br_valid, addr_ok, data_ok;
  logic [31:0]  flush_pc, br_target, rdata, addr, wdata;
  logic         req, wr, fs_valid;
  logic [1:0]   size;
  logic [3:0]   wstrb;
  logic [101:0] fs_bus;
  bit           rsp_en;

  int           tests_run = 0;
  int           tests_failed = 0;
  logic [101:0] exp_q[$];
  logic [31:0]  mem_q[$];
  logic [31:0]  acc_log[$];
  logic [101:0] mon_exp;

  always #5 clk = ~clk;

  if_stage_mo dut (
    .clk              (clk),
    .resetn           (resetn),
    .ds_allowin       (ds_allowin),
    .fs_to_ds_valid   (fs_valid),
    .fs_to_ds_bus     (fs_bus),
    .flush_valid      (flush_valid),
    .flush_pc         (flush_pc),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .inst_sram_req    (req),
    .inst_sram_wr     (wr),
    .inst_sram_size   (size),
    .inst_sram_wstrb  (wstrb),
    .inst_sram_addr   (addr),
    .inst_sram_wdata  (wdata),
    .inst_sram_addr_ok(addr_ok),
    .inst_sram_data_ok(data_ok),
    .inst_sram_rdata  (rdata)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [101:0] ok_entry(input logic [31:0] pc);
    return {1'b0, 5'd0, 32'd0, inst_of(pc), pc};
  endfunction

  task automatic check(input string tag, input logic [101:0] obs, input logic [101:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds addr_ok high until exactly n requests are accepted, bounded by a cycle budget.
  task automatic issue_n(input string tag, input int n);
    int got;
    got = 0;
    addr_ok = 1'b1;
    for (int c = 0; c < 40 && got < n; c++) begin
      @(negedge clk);
      if (req) got++;
      @(posedge clk);
      #1;
    end
    addr_ok = 1'b0;
    check(tag, 102'(got), 102'(n));
  endtask

  // SRAM responder: one-cycle latency, in-order, data = inst_of(addr).
  always @(negedge clk) begin
    if (!resetn) begin
      mem_q.delete();
    end else begin
      if (data_ok) void'(mem_q.pop_front());
      if (req && addr_ok) begin
        mem_q.push_back(addr);
        acc_log.push_back(addr);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    data_ok = rsp_en && resetn && (mem_q.size() != 0);
    rdata   = data_ok ? inst_of(mem_q[0]) : 32'hdead_beef;
  end

  // Delivery monitor against the scoreboard.
  always @(negedge clk) begin
    if (resetn && fs_valid && ds_allowin) begin
      tests_run++;
      assert (exp_q.size() != 0) else begin
        tests_failed++;
        $error("FAIL unexpected_delivery: observed %h expected none", fs_bus);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("delivery", fs_bus, mon_exp);
      end
    end
  end

  initial begin
    int start;
    resetn = 1'b0; ds_allowin = 1'b1; flush_valid = 1'b0; br_valid = 1'b0;
    flush_pc = '0; br_target = '0; addr_ok = 1'b1; rsp_en = 1'b1; data_ok = 1'b0; rdata = '0;
    cyc(2);
    @(negedge clk);
    check("reset_valid", 102'(fs_valid), 102'(0));
    check("reset_req", 102'(req), 102'(0));
    check("reset_addr", 102'(addr), 102'(ResetPc));

    // Back-to-back delivery and latency.
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.push_back(ok_entry(ResetPc));
    exp_q.push_back(ok_entry(ResetPc + 32'd4));
    exp_q.push_back(ok_entry(ResetPc + 32'd8));
    @(negedge clk);
    check("first_req", 102'(req), 102'(1));
    check("first_addr", 102'(addr), 102'(ResetPc));
    cyc(1);
    @(negedge clk);
    check("latency_c2", 102'(fs_valid), 102'(0));
    cyc(1);
    @(negedge clk);
    check("latency_c3", 102'(fs_valid), 102'(1));
    cyc(1);
    addr_ok = 1'b0;
    @(negedge clk);
    check("b2b_c4_valid", 102'(fs_valid), 102'(1));
    check("b2b_c4_pc", 102'(fs_bus[31:0]), 102'(ResetPc + 32'd4));
    cyc(1);
    @(negedge clk);
    check("b2b_c5_valid", 102'(fs_valid), 102'(1));
    cyc(3);
    check("sb_empty_t1", 102'(exp_q.size()), 102'(0));

    // ID stalled: reservation caps issue at IBUF_DEPTH.
    ds_allowin = 1'b0;
    start = acc_log.size();
    addr_ok = 1'b1;
    cyc(8);
    @(negedge clk);
    check("stall_issued", 102'(acc_log.size() - start), 102'(4));
    check("stall_req_low", 102'(req), 102'(0));
    check("stall_valid", 102'(fs_valid), 102'(1));
    cyc(1);
    addr_ok = 1'b0;
    ds_allowin = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(ok_entry(ResetPc + 32'h0c + 32'(4 * i)));
    cyc(6);
    check("sb_empty_t2", 102'(exp_q.size()), 102'(0));

    // Flush with two requests in flight.
    rsp_en = 1'b0;
    issue_n("flush_prefill", 2);
    flush_valid = 1'b1; flush_pc = 32'h8000_0380; addr_ok = 1'b1;
    @(negedge clk);
    check("flush_noreq", 102'(req), 102'(0));
    cyc(1);
    flush_valid = 1'b0;
    rsp_en = 1'b1;
    exp_q.push_back(ok_entry(32'h8000_0380));
    issue_n("flush_refetch", 1);
    cyc(4);
    check("sb_empty_t3", 102'(exp_q.size()), 102'(0));

    // Branch with IBUF holding {0x10,0x14,0x18}.
    flush_valid = 1'b1; flush_pc = 32'h10;
    cyc(1);
    flush_valid = 1'b0;
    ds_allowin = 1'b0;
    issue_n("br_fill", 3);
    cyc(3);
    br_valid = 1'b1; br_target = 32'h40;
    exp_q.push_back(ok_entry(32'h10));
    exp_q.push_back(ok_entry(32'h40));
    @(negedge clk);
    check("br_head_pc", 102'(fs_bus[31:0]), 102'(32'h10));
    check("br_noreq", 102'(req), 102'(0));
    cyc(1);
    br_valid = 1'b0;
    ds_allowin = 1'b1;
    issue_n("br_target_issue", 1);
    cyc(4);
    check("sb_empty_t4", 102'(exp_q.size()), 102'(0));

    // Branch before the delay slot has been requested.
    flush_valid = 1'b1; flush_pc = 32'h14;
    cyc(1);
    flush_valid = 1'b0;
    br_valid = 1'b1; br_target = 32'h40;
    cyc(1);
    br_valid = 1'b0;
    exp_q.push_back(ok_entry(32'h14));
    exp_q.push_back(ok_entry(32'h40));
    start = acc_log.size();
    issue_n("slot_issue", 2);
    cyc(4);
    check("slot_first_addr", 102'(acc_log[start]), 102'(32'h14));
    check("slot_second_addr", 102'(acc_log[start + 1]), 102'(32'h40));
    check("sb_empty_t5", 102'(exp_q.size()), 102'(0));

    // Misaligned redirect raises AdEL without touching the SRAM.
    flush_valid = 1'b1; flush_pc = 32'h8000_0002; addr_ok = 1'b1;
    cyc(1);
    flush_valid = 1'b0;
    exp_q.push_back({1'b1, 5'h04, 32'h8000_0002, 32'd0, 32'h8000_0002});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("adel_noreq", 102'(req), 102'(0));
      cyc(1);
    end
    cyc(2);
    addr_ok = 1'b0;
    check("sb_empty_t6", 102'(exp_q.size()), 102'(0));

    // Asynchronous reset in the middle of a burst.
    flush_valid = 1'b1; flush_pc = 32'h100;
    cyc(1);
    flush_valid = 1'b0;
    ds_allowin = 1'b0;
    issue_n("burst_fill", 2);
    addr_ok = 1'b1;
    cyc(1);
    resetn = 1'b0;
    #1;
    check("midreset_valid", 102'(fs_valid), 102'(0));
    check("midreset_req", 102'(req), 102'(0));
    check("midreset_addr", 102'(addr), 102'(ResetPc));
    cyc(2);
    resetn = 1'b1;
    ds_allowin = 1'b1;
    exp_q.push_back(ok_entry(ResetPc));
    issue_n("post_reset_issue", 1);
    cyc(4);
    check("sb_empty_final", 102'(exp_q.size()), 102'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
